gb_cpu_bus_bridge: RTL
======================

Name: gb_cpu_bus_bridge

Overview:
- Sits directly downstream of the GB-mode CPU wrapper. Consumes its registered strobes (mreq_n/rd_n/wr_n/iorq_n/m1_n), address and write data.
- Converts each CPU access into a single req/ack transaction toward the system memory arbiter.
- Drives the CPU's wait_n and di inputs, stretching T2 until memory answers.
- Also answers interrupt-acknowledge cycles with a vector byte, without touching memory.

Parameters:
- IDLE_DATA, 8'hFF, byte returned for I/O reads and timeouts.
- TIMEOUT_CYC, 255, cycles to wait for mem_ack before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_a  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_mreq_n  in  1  CPU memory request, active low
- cpu_iorq_n  in  1  CPU I/O request, active low
- cpu_rd_n  in  1  CPU read strobe, active low
- cpu_wr_n  in  1  CPU write strobe, active low
- cpu_m1_n  in  1  CPU opcode-fetch / interrupt-ack marker, active low
- cpu_di  out  8  read data to CPU
- cpu_wait_n  out  1  wait request to CPU, active low
- int_vector  in  8  vector byte supplied on interrupt acknowledge
- mem_req  out  1  memory request; level, held until ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  16  latched address
- mem_wdata  out  8  latched write data
- mem_ack  in  1  one-cycle acknowledge; read data valid in the same cycle
- mem_rdata  in  8  read data
- busy  out  1  high while in REQ or DONE

Behaviour:
- Reset values: state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; cpu_di=IDLE_DATA; busy=0.
  - Reset mid-transaction aborts it; mem_req falls on the next clk.
- start = IDLE & ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n).
- cpu_wait_n is combinational: 0 when start or state==REQ, else 1.
  - This lets the CPU see wait in the same T2 the strobe appears.
- State machine:
  - IDLE→REQ on start.
    - Latch cpu_a→mem_addr.
    - Set mem_we=~cpu_wr_n.
    - Latch cpu_dout→mem_wdata.
    - Set mem_req=1 (registered; visible the clk after start).
  - REQ: hold mem_req and the latched fields stable. On mem_ack→DONE:
    - mem_req←0.
    - For reads, cpu_di←mem_rdata.
  - DONE: wait_n=1; cpu_di held. →IDLE when cpu_rd_n & cpu_wr_n are both 1 (strobes released).
    - No new access is accepted in DONE, so a single strobe cannot be double-counted.
- mem_ack outside REQ is ignored. mem_ack never arrives in the same cycle mem_req first rises; the bridge does not depend on it not arriving.
- Interrupt acknowledge (~cpu_m1_n & ~cpu_iorq_n):
  - cpu_di←int_vector on every clk during the cycle; no mem_req; wait_n=1.
- I/O read (~cpu_iorq_n & cpu_m1_n & ~cpu_rd_n): cpu_di←IDLE_DATA, no wait.
- I/O write: ignored.
- Simultaneous rd_n and wr_n low: treat as a write.
- cpu_a/cpu_dout changes after latch have no effect until the next start.
- busy = (state != IDLE).

Optional Feature:
- Macro GB_BUS_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to REQ and increments each REQ cycle. When the count reaches TIMEOUT_CYC without mem_ack:
  - mem_req←0;
  - cpu_di←IDLE_DATA;
  - a sticky output timeout_err (extra port, 1 bit, cleared by reset) sets;
  - state→DONE.
- Not defined: no counter and no timeout_err port; REQ waits indefinitely.

Test Plan:
- Read, ack 3 clk after mem_req: cpu_a=16'hC123, rd_n=0, mem_rdata=8'h5A.
  - mem_addr=C123, mem_we=0.
  - cpu_wait_n low from strobe until the ack cycle.
  - cpu_di=5A the clk after ack.
  - mem_req low the clk after ack.
- Write: cpu_a=16'hFF80, cpu_dout=8'h3C, wr_n=0, ack after 1 clk.
  - mem_we=1, mem_wdata=3C.
  - Exactly one mem_req pulse even though wr_n is held low 4 clks.
- Interrupt ack: m1_n=0, iorq_n=0, int_vector=8'h48.
  - cpu_di=48, mem_req stays 0, cpu_wait_n stays 1.
- Reset in REQ: assert reset 2 clk after mem_req rises.
  - Next clk: mem_req=0, busy=0, cpu_di=FF, cpu_wait_n=1.
  - After release, a new read proceeds normally.
- Stray ack in IDLE with mem_rdata=8'h99: cpu_di unchanged, state stays IDLE.
- GB_BUS_TIMEOUT_EN, TIMEOUT_CYC=4, never ack a read.
  - mem_req drops after 4 REQ cycles.
  - cpu_di=FF, timeout_err=1, cpu_wait_n releases.

Source files
------------

// File: rtl/gb_cpu_bus_bridge.sv
// gb_cpu_bus_bridge
// Turns each GB-mode CPU memory access into a single req/ack transaction
// toward the system memory arbiter. It stretches the CPU's T2 through
// cpu_wait_n until memory answers. Interrupt-acknowledge cycles are answered
// locally with int_vector, and I/O reads return IDLE_DATA.
//
// Optional feature: define GB_BUS_TIMEOUT_EN to add a REQ timeout.
// That build also adds the TIMEOUT_CYC parameter and the sticky timeout_err
// output. Without it, REQ waits for mem_ack indefinitely.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   cpu_a, cpu_dout             CPU address / write data
//   cpu_mreq_n, cpu_iorq_n,
//   cpu_rd_n, cpu_wr_n,
//   cpu_m1_n                    CPU strobes (active low)
//   cpu_di                      registered read data to the CPU
//   cpu_wait_n                  combinational wait request (active low)
//   int_vector                  byte returned on interrupt acknowledge
//   mem_req, mem_we,
//   mem_addr, mem_wdata         request toward the arbiter; held stable while mem_req
//   mem_ack, mem_rdata          one-cycle acknowledge; read data valid with ack
//   busy                        high while a transaction is in flight (REQ or DONE)
//   timeout_err                 (GB_BUS_TIMEOUT_EN only) sticky timeout flag
//
// Handshake: mem_req is a level that rises the clock after the CPU strobe
// and stays high until the cycle in which mem_ack is seen. mem_we, mem_addr
// and mem_wdata do not change while mem_req is high.
module gb_cpu_bus_bridge #(
`ifdef GB_BUS_TIMEOUT_EN
    parameter int         TIMEOUT_CYC = 255,
`endif
    parameter logic [7:0] IDLE_DATA   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
`ifdef GB_BUS_TIMEOUT_EN
    output logic        timeout_err,
`endif
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_m1_n,
    output logic [7:0]  cpu_di,
    output logic        cpu_wait_n,
    input  logic [7:0]  int_vector,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  cpu_di_q, cpu_di_d;

    logic start;
    logic int_ack;
    logic io_read;
    logic timeout_hit;

    assign start   = (state_q == ST_IDLE) & ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n);
    assign int_ack = ~cpu_m1_n & ~cpu_iorq_n;
    assign io_read = ~cpu_iorq_n & cpu_m1_n & ~cpu_rd_n;

`ifdef GB_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_err_q, timeout_err_d;

    // cnt_q holds the number of REQ cycles already completed. The timeout
    // fires at the end of the TIMEOUT_CYC-th REQ cycle. An ack in that same
    // cycle still wins.
    assign timeout_hit = (state_q == ST_REQ) & ~mem_ack & (cnt_q == TIMEOUT_LAST);

    always_comb begin
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q | timeout_hit;
        if (start) begin
            cnt_d = 8'd0;
        end else if (state_q == ST_REQ) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_di_d    = cpu_di_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_REQ;
                    mem_req_d   = 1'b1;
                    // rd_n and wr_n both low is treated as a write.
                    mem_we_d    = ~cpu_wr_n;
                    mem_addr_d  = cpu_a;
                    mem_wdata_d = cpu_dout;
                end else if (int_ack) begin
                    cpu_di_d = int_vector;
                end else if (io_read) begin
                    cpu_di_d = IDLE_DATA;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_di_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    cpu_di_d  = IDLE_DATA;
                end
            end
            ST_DONE: begin
                // Stay here until the strobe is released so one CPU access
                // produces exactly one memory transaction.
                if (cpu_rd_n && cpu_wr_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            cpu_di_q    <= IDLE_DATA;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_di_q    <= cpu_di_d;
        end
    end

    // Wait is combinational so the CPU sees it in the same T2 the strobe appears.
    assign cpu_wait_n = ~(start | (state_q == ST_REQ));
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_di     = cpu_di_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
